// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg: shared op/state encodings and counter sizing for the multi-cycle mul/div unit
package ex_muldiv_ctrl_pkg;
  typedef enum logic [1:0] {MD_MUL = 2'b00, MD_MULHU = 2'b01, MD_DIVU = 2'b10, MD_REMU = 2'b11} md_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_e;
  localparam int XLEN_DEF = 32;
  function automatic int md_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction
  localparam int MD_CNT_W = md_cnt_w(XLEN_DEF);
endpackage

// File: rtl/ex_muldiv_ctrl_step.sv
// muldiv_step: one shift-add multiply iteration and one restoring divide iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN:0]     rem,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   mcand,
  input  logic [XLEN-1:0]   dvsr,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN:0]     rem_nxt,
  output logic [XLEN-1:0]   quo_nxt
);
  logic [XLEN:0]   sum;
  logic [XLEN+1:0] shl;
  logic            ge;
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[XLEN-1:1]};
    shl     = {rem, quo[XLEN-1]};
    ge      = shl >= {2'b00, dvsr};
    rem_nxt = (XLEN+1)'(ge ? shl - {2'b00, dvsr} : shl);
    quo_nxt = {quo[XLEN-2:0], ge};
  end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative unsigned MUL/MULHU/DIVU/REMU controller with pipeline stall and flush
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_start,
  input  logic [1:0]      EX_md_op,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic            EX_flush,
  output logic            EX_stall,
  output logic            EX_md_valid,
  output logic [XLEN-1:0] EX_md_out
);
  localparam int CW = md_cnt_w(XLEN);
  state_e            state_q, state_d;
  md_op_e            op_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_q, b_q, quo_q, quo_nxt;
  logic [XLEN:0]     rem_q, rem_nxt;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic              go, div0;
  assign go   = state_q == IDLE && EX_start && !EX_flush;
  assign div0 = EX_md_op[1] && EX_b == '0;
  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc(acc_q), .rem(rem_q), .quo(quo_q), .mcand(a_q), .dvsr(b_q),
    .acc_nxt(acc_nxt), .rem_nxt(rem_nxt), .quo_nxt(quo_nxt)
  );
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = EX_flush         ? IDLE :
              state_q == IDLE  ? (go ? (div0 ? DONE : BUSY) : IDLE) :
              state_q == BUSY  ? (cnt_q == CW'(1) ? DONE : BUSY) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= MD_MUL;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (go) begin
      op_q  <= md_op_e'(EX_md_op);
      a_q   <= EX_a;
      b_q   <= EX_b;
      cnt_q <= div0 ? '0 : CW'(XLEN);
      acc_q <= {{XLEN{1'b0}}, EX_b};
      rem_q <= div0 ? {1'b0, EX_a} : '0;
      quo_q <= div0 ? '1 : EX_a;
    end else if (state_q == BUSY) begin
      acc_q <= acc_nxt;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end
  always_comb begin
    EX_stall    = go || (state_q == BUSY && !EX_flush);
    EX_md_valid = state_q == DONE && !EX_flush;
    EX_md_out   = !EX_md_valid       ? '0 :
                  op_q == MD_MUL     ? acc_q[XLEN-1:0] :
                  op_q == MD_MULHU   ? acc_q[2*XLEN-1:XLEN] :
                  op_q == MD_DIVU    ? quo_q : rem_q[XLEN-1:0];
  end
endmodule
